// File: rtl/clkdiv_sel_ctrl.sv
// Button-to-select control for the clock divider: 2-FF sync + debounce FSM per button, +/-1 select step.
// Latency: button stable from edge k -> sel_o/chg_o update at edge k+DB_CNT+3. No backpressure.
// Boundary at 7/0 saturates by default; define SELCTRL_WRAP_EN to wrap instead.
module clkdiv_sel_ctrl #(
    parameter int unsigned DB_CNT  = 50000,
    parameter int unsigned CNT_W   = 16,
    parameter logic [2:0]  SEL_RST = 3'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_up_i,
    input  logic       btn_dn_i,
    output logic [2:0] sel_o,
    output logic       chg_o
);

`ifdef SELCTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_W,
        DB_HELD,
        DB_REL_W
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_dn_i, btn_up_i};

    // Index 0 = up button, index 1 = down button; both paths are identical.
    for (genvar b = 0; b < 2; b++) begin : g_db
        logic             s1_q;
        logic             s2_q;
        db_state_t        st_q;
        logic [CNT_W-1:0] cnt_q;
        logic             press_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                st_q    <= DB_IDLE;
                cnt_q   <= '0;
                press_q <= 1'b0;
            end else begin
                s1_q    <= btn_raw[b];
                s2_q    <= s1_q;
                press_q <= 1'b0;
                case (st_q)
                    DB_IDLE: begin
                        if (s2_q) begin
                            st_q  <= DB_PRESS_W;
                            cnt_q <= '0;
                        end
                    end
                    DB_PRESS_W: begin
                        if (!s2_q) begin
                            st_q  <= DB_IDLE;
                            cnt_q <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            st_q    <= DB_HELD;
                            cnt_q   <= '0;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    DB_HELD: begin
                        if (!s2_q) begin
                            st_q  <= DB_REL_W;
                            cnt_q <= '0;
                        end
                    end
                    DB_REL_W: begin
                        // Bounce while releasing falls back to HELD, so no second press.
                        if (s2_q) begin
                            st_q  <= DB_HELD;
                            cnt_q <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            st_q  <= DB_IDLE;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        st_q  <= DB_IDLE;
                        cnt_q <= '0;
                    end
                endcase
            end
        end

        assign press[b] = press_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_o <= SEL_RST;
            chg_o <= 1'b0;
        end else begin
            chg_o <= 1'b0;
            case (press)
                2'b01: begin
                    if (WRAP || sel_o != 3'd7) begin
                        sel_o <= sel_o + 3'd1;
                        chg_o <= 1'b1;
                    end
                end
                2'b10: begin
                    if (WRAP || sel_o != 3'd0) begin
                        sel_o <= sel_o - 3'd1;
                        chg_o <= 1'b1;
                    end
                end
                default: begin
                    sel_o <= sel_o;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_sel_ctrl.sv
// Bench for clkdiv_sel_ctrl: directed scenarios plus random button activity against a run-length model.
module tb_clkdiv_sel_ctrl;

    localparam int DB = 4;
`ifdef SELCTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       up;
    logic       dn;
    logic [2:0] sel;
    logic       chg;

    always #5 clk = ~clk;

    clkdiv_sel_ctrl #(
        .DB_CNT (DB),
        .CNT_W  (4),
        .SEL_RST(3'd0)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_up_i(up),
        .btn_dn_i(dn),
        .sel_o   (sel),
        .chg_o   (chg)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: raw input reaches the debouncer two edges late; the debounced
    // level flips after DB+1 consecutive samples disagreeing with it.
    int m_sel;
    int m_chg;
    int t;
    int chg_seen;
    bit dly1[2];
    bit dly2[2];
    bit lvl[2];
    bit pend[2];
    int run[2];
    bit raw[2];

    task step();
        @(posedge clk);
        raw[0] = up;
        raw[1] = dn;
        if (rst) begin
            m_sel = 0;
            m_chg = 0;
            for (int b = 0; b < 2; b++) begin
                dly1[b] = 0; dly2[b] = 0; lvl[b] = 0; pend[b] = 0; run[b] = 0;
            end
        end else begin
            m_chg = 0;
            if (pend[0] != pend[1]) begin
                t = m_sel + (pend[0] ? 1 : -1);
                if (t > 7 || t < 0) t = WRAP ? (t & 7) : m_sel;
                m_chg = (t != m_sel) ? 1 : 0;
                m_sel = t;
            end
            for (int b = 0; b < 2; b++) begin
                pend[b] = 0;
                if (dly2[b] != lvl[b]) begin
                    run[b]++;
                    if (run[b] == DB + 1) begin
                        lvl[b]  = dly2[b];
                        pend[b] = dly2[b];
                        run[b]  = 0;
                    end
                end else begin
                    run[b] = 0;
                end
                dly2[b] = dly1[b];
                dly1[b] = raw[b];
            end
        end
        #1;
        if (chg === 1'b1) chg_seen++;
        chk("sel", int'(sel), m_sel);
        chk("chg", int'(chg), m_chg);
    endtask

    task press(input bit u, input bit d, input int hold, input int gap);
        up = u;
        dn = d;
        repeat (hold) step();
        up = 0;
        dn = 0;
        repeat (gap) step();
    endtask

    task do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    int cnt;

    initial begin
        rst = 1; up = 0; dn = 0;
        step();
        step();
        rst = 0;

        // Idle after reset
        repeat (20) step();
        chk("t1_sel", int'(sel), 0);

        // Single clean up press, exact latency
        up = 1;
        step();
        repeat (6) begin
            step();
            chk("t2_early", int'(sel), 0);
        end
        step();
        chk("t2_sel", int'(sel), 1);
        chk("t2_chg", int'(chg), 1);
        step();
        chk("t2_chg_drop", int'(chg), 0);
        repeat (3) step();
        up = 0;
        repeat (12) step();

        // Glitches shorter than the debounce window
        chg_seen = 0;
        press(1, 0, 3, 10);
        press(1, 0, 3, 10);
        press(0, 1, 2, 10);
        press(0, 1, 2, 10);
        chk("t3_sel", int'(sel), 1);
        chk("t3_chg", chg_seen, 0);

        // Boundary at 7 and 0
        do_reset();
        repeat (7) press(1, 0, 10, 10);
        chk("t4_sel7", int'(sel), 7);
        chg_seen = 0;
        press(1, 0, 10, 10);
        chk("t4_up8_sel", int'(sel), WRAP ? 0 : 7);
        chk("t4_up8_chg", chg_seen, WRAP ? 1 : 0);
        do_reset();
        chg_seen = 0;
        press(0, 1, 10, 10);
        chk("t4_dn_sel", int'(sel), WRAP ? 7 : 0);
        chk("t4_dn_chg", chg_seen, WRAP ? 1 : 0);

        // Simultaneous up and down
        do_reset();
        repeat (3) press(1, 0, 10, 10);
        chk("t5_pre", int'(sel), 3);
        chg_seen = 0;
        press(1, 1, 10, 10);
        chk("t5_sel", int'(sel), 3);
        chk("t5_chg", chg_seen, 0);

        // Reset in the middle of a held press
        up = 1;
        step();
        repeat (4) step();
        rst = 1;
        step();
        rst = 0;
        chk("t6_sel0", int'(sel), 0);
        cnt = 0;
        while (sel !== 3'd1 && cnt < 30) begin
            step();
            cnt++;
        end
        chk("t6_lat", cnt, 8);
        up = 0;
        repeat (12) step();

        // Random button activity with occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) up = ~up;
            if ($urandom_range(0, 5) == 0) dn = ~dn;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 0; up = 0; dn = 0;
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
